// File: rtl/axis_block_engine_shell.sv
`default_nettype none
// ============================================================================
//  Module   : axis_block_engine_shell
//  Purpose  : AXI4-Stream packet shell around a start/done block engine.
//             Collects one IN_WORDS-word input packet, hands it to the engine,
//             then streams the OUT_WORDS-word result back out as one packet.
//             Short packets are zero padded, overlong packets are drained,
//             error flags are sticky and completed packets are counted.
//  Config   : AXIS_SHELL_WATCHDOG_EN - when defined, an engine watchdog of
//             WDOG_CYCLES PROC cycles aborts a hung engine (eng_abort, sts[2]).
//  Ports    :
//    AXIS_ACLK / AXIS_ARESETN     clock, asynchronous active-low reset
//    S_AXIS_*                     input stream sink (TSTRB ignored)
//    M_AXIS_*                     output stream source (TSTRB all-ones)
//    eng_start / eng_in_blk       engine start pulse and input block
//    eng_done  / eng_out_blk      engine done pulse and result block
//    eng_abort                    engine abort pulse (watchdog build only)
//    sts / sts_clr                {busy, timeout, overrun, short}; clear [2:0]
//    pkt_count                    completed output packets, wraps at 2^16
//  Revision : 1.0 - initial release
// ============================================================================
module axis_block_engine_shell #(
  parameter int DATA_WIDTH  = 32,
  parameter int IN_WORDS    = 8,
  parameter int OUT_WORDS   = 8,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic                            AXIS_ACLK,
  input  logic                            AXIS_ARESETN,
  input  logic [DATA_WIDTH-1:0]           S_AXIS_TDATA,
  input  logic [DATA_WIDTH/8-1:0]         S_AXIS_TSTRB,
  input  logic                            S_AXIS_TLAST,
  input  logic                            S_AXIS_TVALID,
  output logic                            S_AXIS_TREADY,
  output logic [DATA_WIDTH-1:0]           M_AXIS_TDATA,
  output logic [DATA_WIDTH/8-1:0]         M_AXIS_TSTRB,
  output logic                            M_AXIS_TLAST,
  output logic                            M_AXIS_TVALID,
  input  logic                            M_AXIS_TREADY,
  output logic                            eng_start,
  output logic [IN_WORDS*DATA_WIDTH-1:0]  eng_in_blk,
  input  logic                            eng_done,
  input  logic [OUT_WORDS*DATA_WIDTH-1:0] eng_out_blk,
  output logic                            eng_abort,
  output logic [3:0]                      sts,
  input  logic                            sts_clr,
  output logic [15:0]                     pkt_count
);

  localparam int IPW = $clog2(IN_WORDS);
  localparam int OPW = $clog2(OUT_WORDS);
  localparam logic [IPW-1:0] LAST_IN  = IPW'(IN_WORDS - 1);
  localparam logic [OPW-1:0] LAST_OUT = OPW'(OUT_WORDS - 1);

  typedef enum logic [1:0] {
    S_RECV  = 2'd0,
    S_DRAIN = 2'd1,
    S_PROC  = 2'd2,
    S_SEND  = 2'd3
  } state_t;

  state_t                                   state_q, state_d;
  logic [IPW-1:0]                           wr_ptr_q, wr_ptr_d;
  logic [OPW-1:0]                           rd_ptr_q, rd_ptr_d;
  logic [IN_WORDS-1:0][DATA_WIDTH-1:0]      in_buf_q, in_buf_d;
  logic [IN_WORDS-1:0]                      valid_q, valid_d;
  logic [OUT_WORDS-1:0][DATA_WIDTH-1:0]     out_buf_q, out_buf_d;
  logic                                     first_q, first_d;
  logic [2:0]                               sts_q, sts_d;
  logic [15:0]                              pkt_q, pkt_d;

`ifdef AXIS_SHELL_WATCHDOG_EN
  localparam int WDW = $clog2(WDOG_CYCLES + 1);
  localparam logic [WDW-1:0] WDOG_LAST = WDW'(WDOG_CYCLES - 1);
  logic [WDW-1:0] wdog_q, wdog_d;
  logic           abort_q, abort_d;
  logic           unused_ok;
  assign unused_ok = ^S_AXIS_TSTRB;
`else
  logic           unused_ok;
  assign unused_ok = ^{S_AXIS_TSTRB, 1'(WDOG_CYCLES)};
`endif

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    in_buf_d  = in_buf_q;
    valid_d   = valid_q;
    out_buf_d = out_buf_q;
    first_d   = 1'b0;
    // A flag raised below in the same cycle as sts_clr overrides the clear.
    sts_d     = sts_clr ? 3'b000 : sts_q;
    pkt_d     = pkt_q;
`ifdef AXIS_SHELL_WATCHDOG_EN
    // Counts PROC cycles; zero on the first PROC cycle (the eng_start cycle).
    wdog_d    = (state_q == S_PROC) ? wdog_q + WDW'(1) : '0;
    abort_d   = 1'b0;
`endif

    case (state_q)
      S_RECV: begin
        if (S_AXIS_TVALID) begin
          in_buf_d[wr_ptr_q] = S_AXIS_TDATA;
          valid_d[wr_ptr_q]  = 1'b1;
          if (wr_ptr_q == LAST_IN) begin
            // Pointer saturates here; it is cleared when the packet completes.
            first_d = 1'b1;
            if (S_AXIS_TLAST) begin
              state_d = S_PROC;
            end else begin
              sts_d[1] = 1'b1;
              state_d  = S_DRAIN;
              first_d  = 1'b0;
            end
          end else begin
            wr_ptr_d = wr_ptr_q + IPW'(1);
            if (S_AXIS_TLAST) begin
              sts_d[0] = 1'b1;
              state_d  = S_PROC;
              first_d  = 1'b1;
            end
          end
        end
      end

      S_DRAIN: begin
        if (S_AXIS_TVALID && S_AXIS_TLAST) begin
          state_d = S_PROC;
          first_d = 1'b1;
        end
      end

      S_PROC: begin
        if (eng_done) begin
          out_buf_d = eng_out_blk;
          state_d   = S_SEND;
        end
`ifdef AXIS_SHELL_WATCHDOG_EN
        else if (wdog_q == WDOG_LAST) begin
          abort_d  = 1'b1;
          sts_d[2] = 1'b1;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          valid_d  = '0;
          state_d  = S_RECV;
        end
`endif
      end

      S_SEND: begin
        if (M_AXIS_TREADY) begin
          if (rd_ptr_q == LAST_OUT) begin
            pkt_d    = pkt_q + 16'd1;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            valid_d  = '0;
            state_d  = S_RECV;
          end else begin
            rd_ptr_d = rd_ptr_q + OPW'(1);
          end
        end
      end

      default: state_d = S_RECV;
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      state_q   <= S_RECV;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      in_buf_q  <= '0;
      valid_q   <= '0;
      out_buf_q <= '0;
      first_q   <= 1'b0;
      sts_q     <= '0;
      pkt_q     <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      in_buf_q  <= in_buf_d;
      valid_q   <= valid_d;
      out_buf_q <= out_buf_d;
      first_q   <= first_d;
      sts_q     <= sts_d;
      pkt_q     <= pkt_d;
    end
  end

`ifdef AXIS_SHELL_WATCHDOG_EN
  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      wdog_q  <= '0;
      abort_q <= 1'b0;
    end else begin
      wdog_q  <= wdog_d;
      abort_q <= abort_d;
    end
  end

  // Registered so the abort never depends combinationally on eng_done.
  assign eng_abort = abort_q;
`else
  assign eng_abort = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Output decode
  // --------------------------------------------------------------------------
  // Words never written for the current packet are presented as zero.
  for (genvar gi = 0; gi < IN_WORDS; gi++) begin : g_in_blk
    assign eng_in_blk[gi*DATA_WIDTH +: DATA_WIDTH] =
      valid_q[gi] ? in_buf_q[gi] : '0;
  end

  assign S_AXIS_TREADY = (state_q == S_RECV) || (state_q == S_DRAIN);
  assign M_AXIS_TVALID = (state_q == S_SEND);
  assign M_AXIS_TDATA  = (state_q == S_SEND) ? out_buf_q[rd_ptr_q] : '0;
  assign M_AXIS_TLAST  = (state_q == S_SEND) && (rd_ptr_q == LAST_OUT);
  assign M_AXIS_TSTRB  = '1;
  assign eng_start     = (state_q == S_PROC) && first_q;
  assign sts           = {!((state_q == S_RECV) && (wr_ptr_q == '0)), sts_q};
  assign pkt_count     = pkt_q;

endmodule
`default_nettype wire

// File: doc/axis_block_engine_shell.md
# axis_block_engine_shell

Parametrised AXI4-Stream packet shell that wraps a block-processing engine, such as the SHA-256 miner core, between a stream sink and a stream source on a single clock. It collects one input packet of IN_WORDS words and hands it to the engine through a start/done interface. It then streams the engine's OUT_WORDS-word result back out as one packet. It adds short-packet padding, overlong-packet draining, sticky error status and a packet counter.

## Interface
Parameters:
- DATA_WIDTH, 32: stream word width in bits; must be a multiple of 8.
- IN_WORDS, 8: words per input block; must be 2 or more.
- OUT_WORDS, 8: words per output block; must be 2 or more.
- WDOG_CYCLES, 1024: engine watchdog limit in cycles; used only with the configuration macro.

Ports:
- AXIS_ACLK, in, 1: the single clock.
- AXIS_ARESETN, in, 1: asynchronous, active-low reset.
- S_AXIS_TDATA, in, DATA_WIDTH: input word.
- S_AXIS_TSTRB, in, DATA_WIDTH/8: ignored.
- S_AXIS_TLAST, in, 1: marks the end of the input packet.
- S_AXIS_TVALID, in, 1: input word is valid.
- S_AXIS_TREADY, out, 1: the shell accepts an input word.
- M_AXIS_TDATA, out, DATA_WIDTH: output word.
- M_AXIS_TSTRB, out, DATA_WIDTH/8: constant all-ones.
- M_AXIS_TLAST, out, 1: marks the last output word.
- M_AXIS_TVALID, out, 1: output word is valid.
- M_AXIS_TREADY, in, 1: downstream accepts the output word.
- eng_start, out, 1: one-cycle pulse that starts the engine.
- eng_in_blk, out, IN_WORDS*DATA_WIDTH: input block; word 0 occupies the LSBs.
- eng_done, in, 1: one-cycle pulse; eng_out_blk is valid in the same cycle.
- eng_out_blk, in, OUT_WORDS*DATA_WIDTH: result block; word 0 occupies the LSBs.
- eng_abort, out, 1: one-cycle pulse that aborts the engine.
- sts, out, 4: status flags; bit0 short, bit1 overrun, bit2 timeout, bit3 busy.
- sts_clr, in, 1: clears sts[2:0].
- pkt_count, out, 16: number of output packets completed.

## Operation
States:
- RECV: S_AXIS_TREADY = 1.
  - Each handshake writes the input buffer at wr_ptr and sets that word's valid bit.
  - A handshake with TLAST at wr_ptr < IN_WORDS-1 sets sts[0] and goes to PROC.
  - A handshake at wr_ptr = IN_WORDS-1 with TLAST goes to PROC.
  - A handshake at wr_ptr = IN_WORDS-1 without TLAST sets sts[1] and goes to DRAIN.
- DRAIN: S_AXIS_TREADY = 1. Words are discarded until a TLAST handshake, then the state goes to PROC.
- PROC:
  - eng_start is high only on the first PROC cycle.
  - eng_in_blk presents words whose valid bit is clear as zero.
  - eng_done is honoured on any PROC cycle, including the start cycle; that cycle captures eng_out_blk into the output buffer and goes to SEND.
- SEND:
  - M_AXIS_TVALID = 1; M_AXIS_TDATA is output buffer word rd_ptr.
  - M_AXIS_TLAST = (rd_ptr == OUT_WORDS-1).
  - The last handshake increments pkt_count (wrapping at 2^16), clears wr_ptr, rd_ptr and all valid bits, and goes to RECV.
- sts[3] = 1 in every state except RECV when wr_ptr = 0.
- sts[2:0] are sticky. sts_clr clears them; a flag set in the same cycle as sts_clr wins.
- eng_done outside PROC is ignored.
- Pointer widths are clog2 of the respective word count.

## Timing
- Reset is asynchronous. Every register goes to zero and the state goes to RECV. All outputs are 0 in reset except S_AXIS_TREADY = 1 and M_AXIS_TSTRB, which is all-ones.
- Outputs come from registered state through combinational decode; there are no combinational input-to-output paths except the TDATA/TLAST mux on rd_ptr.
- Latency:
  - Final accepted input word at cycle t gives eng_start at t+1.
  - eng_done at cycle d gives M_AXIS_TVALID at d+1.
  - After the last output handshake, S_AXIS_TREADY is high on the next cycle.
- Throughput: one word per cycle in each direction while the partner is ready.
- While M_AXIS_TREADY = 0, TDATA and TLAST are held stable and TVALID is never withdrawn.
- Input and output phases never overlap; S_AXIS_TREADY = 0 during PROC and SEND.

## Configuration
- AXIS_SHELL_WATCHDOG_EN defined:
  - A counter starts at eng_start.
  - If WDOG_CYCLES PROC cycles elapse without eng_done, eng_abort pulses, sts[2] is set, no output packet is sent, and the state returns to RECV with pointers and valid bits cleared.
  - eng_done in the expiry cycle wins over the abort.
- Undefined: no watchdog counter is built, eng_abort is tied to 0, sts[2] is always 0, and PROC waits indefinitely.

## Test plan
- Exact packet: 8 words 0x1..0x8 with TLAST on word 8, engine returns word i = in[i] XOR 0xFFFFFFFF one cycle after start -> eng_start 1 cycle after word 8; output 0xFFFFFFFE..0xFFFFFFF7 with TLAST on word 8; pkt_count = 1; sts[2:0] = 0.
- Short packet: 3 words 0xA,0xB,0xC with TLAST on the third -> eng_in_blk = {0,0,0,0,0,0xC,0xB,0xA}; sts[0] = 1; sts_clr clears it.
- Overlong packet: 11 words with TLAST on word 11 -> only words 1..8 reach the engine; S_AXIS_TREADY stays high through word 11; sts[1] = 1; eng_start follows word 11.
- Back-pressure: M_AXIS_TREADY toggled 1,0,0,1,... -> TDATA stable during stalls; exactly 8 beats; a single TLAST.
- Zero-latency engine: eng_done on the eng_start cycle -> output starts the next cycle; repeating 3 packets gives pkt_count = 3.
- Watchdog with macro, WDOG_CYCLES = 16, eng_done never asserted -> eng_abort pulse; sts[2] = 1; M_AXIS_TVALID never rises; S_AXIS_TREADY returns high. Mid-packet asynchronous reset -> all outputs return to reset values immediately.
